// File: rtl/systolic_mac_array.sv
// rtl/systolic_mac_array.sv - output-stationary systolic MAC array with per-PE readback
// Optional SYSTOLIC_MAC_SATURATE_EN: clamp accumulators on signed overflow and raise sticky sat_flag.
module systolic_mac_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     master_clock,
    input  logic                     reset,
    input  logic [ROWS*DATA_W-1:0]   x_in,
    input  logic [COLS*DATA_W-1:0]   y_in,
    input  logic                     in_valid,
    input  logic                     acc_clear,
    input  logic [7:0]               x_position,
    input  logic [7:0]               y_position,
    input  logic                     rdn,
    output logic [ACC_W-1:0]         output_value,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     sat_flag
);

    localparam int PW = 2 * DATA_W;
    // Row r is one flat shift chain: r skew stages followed by the COLS PE stages.
    localparam int XN = ROWS * COLS + (ROWS * (ROWS - 1)) / 2;
    localparam int YN = ROWS * COLS + (COLS * (COLS - 1)) / 2;

    function automatic int xb(input int r);
        return r * COLS + (r * (r - 1)) / 2;
    endfunction

    function automatic int yb(input int c);
        return c * ROWS + (c * (c - 1)) / 2;
    endfunction

    function automatic logic signed [ACC_W-1:0] product_ext(input logic signed [DATA_W-1:0] x,
                                                            input logic signed [DATA_W-1:0] y);
        logic signed [PW-1:0] p;
        p = PW'(x) * PW'(y);
        return ACC_W'(p);
    endfunction

    logic signed [DATA_W-1:0] x_sk [XN];
    logic signed [DATA_W-1:0] y_sk [YN];
    logic [XN-1:0]            v_x;
    logic signed [ACC_W-1:0]  acc     [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_nxt [ROWS][COLS];
    logic signed [ACC_W-1:0]  rd_value;

`ifdef SYSTOLIC_MAC_SATURATE_EN
    logic [ROWS*COLS-1:0]     clamp_hit;
`endif

    assign busy = |v_x;

    always_comb begin : comb_mac
        logic signed [ACC_W-1:0] e;
        logic signed [ACC_W-1:0] s;
        e = '0;
        s = '0;
`ifdef SYSTOLIC_MAC_SATURATE_EN
        clamp_hit = '0;
`endif
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                e = product_ext(x_sk[xb(r) + r + c], y_sk[yb(c) + c + r]);
                s = acc[r][c] + e;
`ifdef SYSTOLIC_MAC_SATURATE_EN
                if ((acc[r][c][ACC_W-1] == e[ACC_W-1]) && (s[ACC_W-1] != acc[r][c][ACC_W-1])) begin
                    clamp_hit[r*COLS + c] = v_x[xb(r) + r + c];
                    s = acc[r][c][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                end
`endif
                acc_nxt[r][c] = s;
            end
        end
    end

    // Out-of-range positions match no PE and read back as zero.
    always_comb begin
        rd_value = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(y_position) == r && int'(x_position) == c) begin
                    rd_value = acc[r][c];
                end
            end
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            for (int i = 0; i < XN; i++) x_sk[i] <= '0;
            for (int i = 0; i < YN; i++) y_sk[i] <= '0;
            v_x <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
            end
            output_value <= '0;
            out_valid    <= 1'b0;
`ifdef SYSTOLIC_MAC_SATURATE_EN
            sat_flag     <= 1'b0;
`endif
        end else begin
            out_valid <= ~rdn;
            if (!rdn) begin
                output_value <= rd_value;
            end

            for (int r = 0; r < ROWS; r++) begin
                x_sk[xb(r)] <= x_in[r*DATA_W +: DATA_W];
                v_x[xb(r)]  <= in_valid;
                for (int k = 1; k < r + COLS; k++) begin
                    x_sk[xb(r) + k] <= x_sk[xb(r) + k - 1];
                    v_x[xb(r) + k]  <= v_x[xb(r) + k - 1];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                y_sk[yb(c)] <= y_in[c*DATA_W +: DATA_W];
                for (int k = 1; k < c + ROWS; k++) begin
                    y_sk[yb(c) + k] <= y_sk[yb(c) + k - 1];
                end
            end

            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (v_x[xb(r) + r + c]) acc[r][c] <= acc_nxt[r][c];
                end
            end

`ifdef SYSTOLIC_MAC_SATURATE_EN
            if (|clamp_hit) sat_flag <= 1'b1;
`endif

            // Clear overrides every update above, including a same-cycle in_valid.
            if (acc_clear) begin
                v_x <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
                end
`ifdef SYSTOLIC_MAC_SATURATE_EN
                sat_flag <= 1'b0;
`endif
            end
        end
    end

`ifndef SYSTOLIC_MAC_SATURATE_EN
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_mac_array.sv
// tb/tb_systolic_mac_array.sv - scoreboard bench for systolic_mac_array
module tb_systolic_mac_array;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;

    logic                 master_clock = 1'b0;
    logic                 reset;
    logic [ROWS*DW-1:0]   x_in;
    logic [COLS*DW-1:0]   y_in;
    logic                 in_valid;
    logic                 acc_clear;
    logic [7:0]           x_position;
    logic [7:0]           y_position;
    logic                 rdn;
    logic [AW-1:0]        output_value;
    logic                 out_valid;
    logic                 busy;
    logic                 sat_flag;

    always #5 master_clock = ~master_clock;

    systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW)) dut (
        .master_clock (master_clock),
        .reset        (reset),
        .x_in         (x_in),
        .y_in         (y_in),
        .in_valid     (in_valid),
        .acc_clear    (acc_clear),
        .x_position   (x_position),
        .y_position   (y_position),
        .rdn          (rdn),
        .output_value (output_value),
        .out_valid    (out_valid),
        .busy         (busy),
        .sat_flag     (sat_flag)
    );

    int     vectors    = 0;
    int     miscompares = 0;
    int     pulses     = 0;
    int     issued     = 0;
    int     busy_cnt;
    longint exp_q[$];
    longint mon_exp;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge master_clock) begin
        if (out_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got %0d expected no read", $signed(output_value));
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_value", longint'($signed(output_value)), mon_exp);
            end
        end
    end

    task automatic tick();
        @(negedge master_clock);
    endtask

    task automatic read_one(input int x, input int y, input longint exp);
        rdn        = 1'b0;
        x_position = 8'(x);
        y_position = 8'(y);
        exp_q.push_back(exp);
        issued++;
        tick();
    endtask

    task automatic read_all_const(input longint exp);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) read_one(c, r, exp);
        end
        rdn = 1'b1;
        tick();
    endtask

    task automatic clear_pulse();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; x_in = '0; y_in = '0; in_valid = 1'b0; acc_clear = 1'b0;
        x_position = '0; y_position = '0; rdn = 1'b1;
        repeat (3) tick();
        check("reset_value", longint'(output_value), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_sat", longint'(sat_flag), 0);
        reset = 1'b0;
        tick();

        // Test 1: read after reset
        read_one(2, 1, 0);
        rdn = 1'b1;
        check("t1_busy", longint'(busy), 0);
        tick();
        check("t1_pulse_end", longint'(out_valid), 0);

        // Test 2: single pair 3*5, busy width, PE(3,3) update edge
        x_in = {ROWS{16'sd3}};
        y_in = {COLS{16'sd5}};
        in_valid = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
            if (busy) busy_cnt++;
            if (i == 6) read_one_nowait(3, 3, 0);
            if (i == 7) read_one_nowait(3, 3, 15);
            if (i == 8) rdn = 1'b1;
        end
        check("t2_busy_cycles", busy_cnt, 7);
        read_all_const(15);

        // Test 3 + 6: three pairs, reads during accumulation
        clear_pulse();
        for (int r = 0; r < ROWS; r++) x_in[r*DW +: DW] = 16'(r + 1);
        for (int c = 0; c < COLS; c++) y_in[c*DW +: DW] = 16'(-(c + 1));
        in_valid = 1'b1;
        tick();
        tick();
        read_one_nowait(0, 0, -1);
        tick();
        in_valid = 1'b0;
        read_one_nowait(0, 0, -2);
        tick();
        rdn = 1'b1;
        repeat (10) tick();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) read_one(c, r, -3 * (r + 1) * (c + 1));
        end
        rdn = 1'b1;
        tick();
        check("t3_sat", longint'(sat_flag), 0);

        // Test 4: clear 3 cycles after a pair, with in_valid asserted
        clear_pulse();
        x_in = {ROWS{16'sd3}};
        y_in = {COLS{16'sd5}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        acc_clear = 1'b1;
        in_valid = 1'b1;
        tick();
        acc_clear = 1'b0;
        in_valid = 1'b0;
        check("t4_busy_after_clear", longint'(busy), 0);
        repeat (10) tick();
        read_all_const(0);

        // Test 5: 600 pairs of -32768*-32768
        clear_pulse();
        x_in = {ROWS{16'h8000}};
        y_in = {COLS{16'h8000}};
        in_valid = 1'b1;
        repeat (600) tick();
        in_valid = 1'b0;
        repeat (10) tick();
`ifdef SYSTOLIC_MAC_SATURATE_EN
        read_one(0, 0, (longint'(1) <<< 39) - 1);
        read_one(3, 3, (longint'(1) <<< 39) - 1);
        rdn = 1'b1;
        check("t5_sat", longint'(sat_flag), 1);
`else
        read_one(0, 0, -(longint'(424) <<< 30));
        read_one(3, 3, -(longint'(424) <<< 30));
        rdn = 1'b1;
        check("t5_sat", longint'(sat_flag), 0);
`endif
        // Test 6: out-of-range positions while accumulators are non-zero
        read_one(4, 0, 0);
        read_one(0, 4, 0);
        rdn = 1'b1;
        tick();
        clear_pulse();
        check("clear_sat", longint'(sat_flag), 0);
        check("clear_busy", longint'(busy), 0);
        read_one(0, 0, 0);
        rdn = 1'b1;
        repeat (3) tick();

        check("pulse_count", pulses, issued);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic read_one_nowait(input int x, input int y, input longint exp);
        rdn        = 1'b0;
        x_position = 8'(x);
        y_position = 8'(y);
        exp_q.push_back(exp);
        issued++;
    endtask

endmodule
